fifo_rr_ctrl: RTL and testbench
===============================

Name: fifo_rr_ctrl

Overview:
- Controller that shares one synchronous FIFO among NUM_REQ fingerprint sources and sequences its read side for the comparator.
- Write side: round-robin arbiter; the granted source's word is tagged with its source ID and written to the FIFO.
- Read side: converts the FIFO's rd_en/registered data_out interface into a valid/ready stream.
- Also owns FIFO reset (flush sequencing) and enable gating. Sits between the core-side fingerprint ports and the comparator FIFO instance.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..16
- DATA_WIDTH, 32, payload width per requester
- ID_WIDTH, 2, source-tag width; must equal log2(NUM_REQ)
- FLUSH_CYCLES, 2, cycles fifo_rst is held high during a flush; 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  1 = arbitration and reads permitted; 0 = freeze both sides
- flush  in  1  single-cycle request to empty the FIFO
- req_valid  in  NUM_REQ  per-source word valid
- req_data  in  NUM_REQ*DATA_WIDTH  per-source payload; source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; a word transfers when valid&ready
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_data_in  out  ID_WIDTH+DATA_WIDTH  {source_id, payload} to FIFO
- fifo_full  in  1  from FIFO
- fifo_rd_en  out  1  to FIFO rd_en
- fifo_data_out  in  ID_WIDTH+DATA_WIDTH  from FIFO (registered, updates only on read)
- fifo_empty  in  1  from FIFO
- fifo_rst  out  1  active-high reset to FIFO
- out_valid  out  1  comparator stream valid
- out_id  out  ID_WIDTH  source tag of out_data
- out_data  out  DATA_WIDTH  payload
- out_ready  in  1  comparator accepts
- busy  out  1  high in FLUSH state
- accept_cnt  out  16  words written since reset/flush; wraps at 0xFFFF->0

Behaviour:
- Reset (rst=0, async): state=RUN, rr pointer=NUM_REQ-1 (source 0 highest priority first), out_valid=0, fifo_rst=1, flush counter=0, accept_cnt=0, busy=0. All other outputs are 0 while in reset. fifo_rst deasserts on the first clk edge after rst rises.
- FSM states:
  - RUN -> FLUSH on flush=1.
  - FLUSH -> RUN after FLUSH_CYCLES cycles; fifo_rst=1 throughout FLUSH.
  - A flush pulse while already in FLUSH restarts the counter.
- Write arbitration (combinational grant, registered pointer):
  - Eligible when state=RUN, enable=1, fifo_full=0.
  - Grant = first asserted req_valid searching from pointer+1 upward with wrap.
  - req_ready is the one-hot grant; fifo_wr_en = |grant.
  - fifo_data_in = {granted index, granted payload}.
  - On transfer: pointer <= granted index, accept_cnt++.
  - No transfer: pointer holds.
  - req_ready never asserts without the matching req_valid.
- Read sequencing:
  - fifo_rd_en = RUN & enable & !fifo_empty & (!out_valid | out_ready).
  - out_valid is set the cycle after fifo_rd_en.
  - out_valid is cleared on out_valid&out_ready when there is no concurrent rd_en.
  - {out_id, out_data} = fifo_data_out, passed through directly. It is stable while out_valid&!out_ready because rd_en is blocked then.
  - Throughput: 1 word/cycle when out_ready stays high.
- Simultaneous write and read in the same cycle is permitted. The FIFO's internal count handles it; the controller adds no gating.
- enable=0: no grants, no rd_en; a pending out_valid holds until accepted.
- Flush: entering FLUSH drops out_valid immediately (the word is discarded), blocks grants and reads, and clears accept_cnt. A flush takes priority over a write in the same cycle; that write does not occur.
- fifo_full asserts at RAM_DEPTH-1 entries; the controller treats fifo_full as authoritative and never writes while it is high.

Decomposition:
- Package fifo_ctrl_pkg: state encoding (RUN, FLUSH), ID_WIDTH derivation helper, accept_cnt width constant (16).
- Sub-module rr_arbiter (NUM_REQ): inputs req, pointer, en; output one-hot grant and encoded index; purely combinational.
- Flush FSM, pointer, counters and read logic stay in fifo_rr_ctrl.

Test Plan:
- Reset, then all four req_valid held with data 0xA0..0xA3 and out_ready=1 -> FIFO writes in source order 0,1,2,3,0,...; out stream id/data = 0/0xA0, 1/0xA1, 2/0xA2, 3/0xA3; accept_cnt=4 after 4 transfers.
- Only sources 1 and 3 valid -> grants alternate 1,3,1,3; sources 0 and 2 never get req_ready.
- Fill until fifo_full=1 with out_ready=0 -> fifo_wr_en=0, all req_ready=0. Release out_ready -> one word/cycle drains; out_data does not change while out_ready=0.
- Stall: out_valid=1 with data 0x55 and out_ready=0 for 5 cycles, FIFO non-empty -> fifo_rd_en=0 throughout, out_data=0x55 stable. On out_ready=1, the next word appears the following cycle.
- flush pulse with 3 words queued and out_valid=1 -> out_valid=0 next cycle, fifo_rst=1 for exactly 2 cycles, busy=1, accept_cnt=0. After return to RUN, fifo_empty=1 and no out_valid.
- rst asserted mid-transfer (req_valid=1, out_valid=1) -> all outputs cleared asynchronously, fifo_rst=1. After release, the first grant goes to source 0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the round-robin FIFO controller.
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    localparam int ACCEPT_CNT_W = 16;
    localparam int FLUSH_CNT_W  = 4;

    // Tag width needed to name each of n sources.
    function automatic int id_width(input int n);
        int w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_rr_ctrl_arbiter.sv
// Combinational round-robin arbiter: first request strictly after the
// pointer wins, searching upward with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Offset NUM_REQ wraps back to the pointer itself, so it is checked last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = pointer + IDX_W'(k);
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Shares one FIFO among NUM_REQ tagged sources (round-robin write side) and
// turns the FIFO read port into a valid/ready stream, with flush sequencing.
module fifo_rr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int ID_WIDTH     = id_width(NUM_REQ),
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            flush,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_wr_en,
    output logic [ID_WIDTH+DATA_WIDTH-1:0]  fifo_data_in,
    input  logic                            fifo_full,
    output logic                            fifo_rd_en,
    input  logic [ID_WIDTH+DATA_WIDTH-1:0]  fifo_data_out,
    input  logic                            fifo_empty,
    output logic                            fifo_rst,
    output logic                            out_valid,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [ACCEPT_CNT_W-1:0]         accept_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    ctrl_state_e              state_reg, state_next;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic [ID_WIDTH-1:0]      ptr_reg;
    logic                     rst_hold_reg;
    logic                     out_valid_reg;
    logic [ACCEPT_CNT_W-1:0]  accept_cnt_reg;

    logic [DATA_WIDTH-1:0]    req_word [NUM_REQ];
    logic [NUM_REQ-1:0]       grant;
    logic [ID_WIDTH-1:0]      grant_idx;
    logic                     run_ok;
    logic                     wr_ok;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // rst_hold_reg covers the cycle after reset release, while the FIFO is
    // still held in reset; a flush request wins over any transfer that cycle.
    assign run_ok = (state_reg == ST_RUN) && !rst_hold_reg && !flush && enable;
    assign wr_ok  = run_ok && !fifo_full;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_WIDTH)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr_reg),
        .en      (wr_ok),
        .grant   (grant),
        .idx     (grant_idx)
    );

    assign req_ready    = grant;
    assign fifo_wr_en   = |grant;
    assign fifo_data_in = fifo_wr_en ? {grant_idx, req_word[grant_idx]} : '0;
    assign fifo_rd_en   = run_ok && !fifo_empty && (!out_valid_reg || out_ready);

    assign fifo_rst   = rst_hold_reg || (state_reg == ST_FLUSH);
    assign busy       = (state_reg == ST_FLUSH);
    assign out_valid  = out_valid_reg;
    assign accept_cnt = accept_cnt_reg;
    assign {out_id, out_data} = rst_hold_reg ? '0 : fifo_data_out;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                if (flush) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = '0;
                end
            end
            ST_FLUSH: begin
                if (flush) begin
                    flush_cnt_next = '0;
                end else if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_RUN;
            flush_cnt_reg  <= '0;
            ptr_reg        <= ID_WIDTH'(NUM_REQ - 1);
            rst_hold_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
            accept_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            rst_hold_reg  <= 1'b0;

            if (flush) begin
                accept_cnt_reg <= '0;
            end else if (fifo_wr_en) begin
                accept_cnt_reg <= accept_cnt_reg + 1'b1;
            end

            if (fifo_wr_en) begin
                ptr_reg <= grant_idx;
            end

            // A word held at flush time is discarded, not delivered.
            if (flush || state_reg == ST_FLUSH) begin
                out_valid_reg <= 1'b0;
            end else if (fifo_rd_en) begin
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Randomized scoreboard bench for fifo_rr_ctrl with a behavioural FIFO model.
module tb_fifo_rr_ctrl;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int IW  = 2;
    localparam int FC  = 2;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              fifo_wr_en;
    logic [IW+DW-1:0]  fifo_data_in;
    logic              fifo_full;
    logic              fifo_rd_en;
    logic [IW+DW-1:0]  fifo_data_out;
    logic              fifo_empty;
    logic              fifo_rst;
    logic              out_valid;
    logic [IW-1:0]     out_id;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic [15:0]       accept_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_rr_ctrl #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_rst(fifo_rst), .out_valid(out_valid), .out_id(out_id), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .accept_cnt(accept_cnt)
    );

    // Behavioural FIFO: registered read data, full at DEPTH-1 entries.
    logic [IW+DW-1:0] f_mem [DEPTH];
    logic [IW+DW-1:0] f_dout = '0;
    int f_cnt = 0, f_wp = 0, f_rp = 0;

    always @(posedge clk) begin
        if (fifo_rst) begin
            f_cnt <= 0; f_wp <= 0; f_rp <= 0;
        end else begin
            if (fifo_wr_en && f_cnt < DEPTH) begin
                f_mem[f_wp] <= fifo_data_in;
                f_wp <= (f_wp + 1) % DEPTH;
            end
            if (fifo_rd_en && f_cnt > 0) begin
                f_dout <= f_mem[f_rp];
                f_rp <= (f_rp + 1) % DEPTH;
            end
            f_cnt <= f_cnt + ((fifo_wr_en && f_cnt < DEPTH) ? 1 : 0)
                           - ((fifo_rd_en && f_cnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full     = (f_cnt >= DEPTH - 1);
    assign fifo_empty    = (f_cnt == 0);
    assign fifo_data_out = f_dout;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last winner, flush cycles left, words expected out.
    int          m_ptr  = N - 1;
    int          m_left = 0;
    bit          m_hold = 1'b1;
    bit          m_ov   = 1'b0;
    logic [15:0] m_acc  = '0;
    bit          clear_pending = 1'b0;
    logic [IW+DW-1:0] exp_q [$];

    always @(negedge rst) begin
        m_ptr = N - 1; m_left = 0; m_hold = 1'b1; m_ov = 1'b0; m_acc = '0;
        exp_q.delete();
    end

    always @(posedge clk) begin
        if (clear_pending) begin
            exp_q.delete();
            clear_pending = 1'b0;
        end
    end

    always @(negedge clk) begin : model
        bit run_ok, found, e_rd;
        int gidx;
        logic [N-1:0] e_grant;
        run_ok  = (m_left == 0) && !m_hold && !flush && enable;
        found   = 1'b0;
        gidx    = 0;
        e_grant = '0;
        if (run_ok && !fifo_full) begin
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (m_ptr + k) % N;
                if (!found && req_valid[s]) begin
                    found = 1'b1; gidx = s; e_grant[s] = 1'b1;
                end
            end
        end
        e_rd = run_ok && !fifo_empty && (!m_ov || out_ready);

        check("req_ready", 64'(req_ready), 64'(e_grant));
        check("fifo_wr_en", 64'(fifo_wr_en), 64'(found));
        if (found)
            check("fifo_data_in", 64'(fifo_data_in),
                  64'({gidx[IW-1:0], req_data[gidx*DW +: DW]}));
        check("fifo_rd_en", 64'(fifo_rd_en), 64'(e_rd));
        check("fifo_rst", 64'(fifo_rst), 64'(m_hold || m_left > 0));
        check("busy", 64'(busy), 64'(m_left > 0));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("accept_cnt", 64'(accept_cnt), 64'(m_acc));
        if (!rst)
            check("reset_out", 64'({out_id, out_data}), 64'(0));

        if (rst) begin
            int old_left;
            old_left = m_left;
            m_hold = 1'b0;
            if (m_left > 0) m_left = flush ? FC : m_left - 1;
            else if (flush) m_left = FC;
            if (flush) begin
                m_acc = '0; m_ov = 1'b0; clear_pending = 1'b1;
            end else if (old_left > 0) begin
                m_ov = 1'b0;
            end else begin
                if (found) begin
                    m_acc = m_acc + 16'd1;
                    m_ptr = gidx;
                    exp_q.push_back({gidx[IW-1:0], req_data[gidx*DW +: DW]});
                end
                if (e_rd) m_ov = 1'b1;
                else if (m_ov && out_ready) m_ov = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted output word.
    bit               prev_stall = 1'b0;
    logic [IW+DW-1:0] prev_word  = '0;

    always @(negedge clk) begin : monitor
        logic [IW+DW-1:0] exp_w;
        if (prev_stall && out_valid && rst)
            check("stall_stable", 64'({out_id, out_data}), 64'(prev_word));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                exp_w = exp_q.pop_front();
                $display("[TB] out id=%0d data=%08h exp id=%0d data=%08h",
                         out_id, out_data, exp_w[IW+DW-1:DW], exp_w[DW-1:0]);
                check("out_word", 64'({out_id, out_data}), 64'(exp_w));
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_word  = {out_id, out_data};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_fixed_data();
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hA0 + 32'(i);
    endtask

    initial begin
        // Reset, then all sources valid with A0..A3.
        enable = 1'b1; out_ready = 1'b1; req_valid = '1;
        set_fixed_data();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        tick(14);

        // Only sources 1 and 3 requesting.
        req_valid = 4'b1010;
        for (int i = 0; i < 20; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            tick(1);
        end

        // Fill to full with the consumer stalled, then drain.
        req_valid = '1; out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
        tick(16);
        req_valid = '0; out_ready = 1'b1;
        tick(10);

        // Queue some words, stall, then flush.
        req_valid = '1; out_ready = 1'b0;
        tick(4);
        req_valid = '0;
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(6);

        // Randomized traffic with occasional flushes and enable drops.
        for (int i = 0; i < 400; i++) begin
            req_valid = N'($urandom);
            for (int j = 0; j < N; j++) req_data[j*DW +: DW] = $urandom;
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        flush = 1'b0; enable = 1'b1;

        // Asynchronous reset in the middle of traffic.
        req_valid = '1; out_ready = 1'b0;
        set_fixed_data();
        tick(5);
        #2 rst = 1'b0;
        #1;
        check("async_req_ready", 64'(req_ready), 64'(0));
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_fifo_rst", 64'(fifo_rst), 64'(1));
        check("async_accept_cnt", 64'(accept_cnt), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        out_ready = 1'b1;
        tick(12);

        // Drain and confirm nothing was left undelivered.
        req_valid = '0;
        tick(20);
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
